// File: rtl/store_queue_dfx_if.sv
// Push channel (translated stores in) and D$ write port (committed stores out) of the store queue.
// The slave modport is the queue; the master modport is the LSU/D$ side.
interface store_queue_dfx_if #(
  parameter int PLEN = 56,
  parameter int XLEN = 64
);
  logic                valid_i;
  logic                ready_o;
  logic [PLEN-1:0]     paddr_i;
  logic [XLEN-1:0]     data_i;
  logic [XLEN/8-1:0]   be_i;
  logic [1:0]          size_i;

  logic                mem_req_o;
  logic                mem_gnt_i;
  logic [PLEN-1:0]     mem_addr_o;
  logic [XLEN-1:0]     mem_data_o;
  logic [XLEN/8-1:0]   mem_be_o;
  logic [1:0]          mem_size_o;

  // Push: an entry transfers on a cycle with valid_i && ready_o. Drain: mem_req_o and the mem_*
  // fields hold steady until the cycle with mem_req_o && mem_gnt_i, which retires the entry.
  modport slave (
    input  valid_i, paddr_i, data_i, be_i, size_i, mem_gnt_i,
    output ready_o, mem_req_o, mem_addr_o, mem_data_o, mem_be_o, mem_size_o
  );

  modport master (
    output valid_i, paddr_i, data_i, be_i, size_i, mem_gnt_i,
    input  ready_o, mem_req_o, mem_addr_o, mem_data_o, mem_be_o, mem_size_o
  );
endinterface

// File: rtl/store_queue_dfx.sv
// Circular store queue: speculative and committed stores, drain to D$, DFX quiesce handshake.
// Define STORE_FWD_EN to add store-to-load forwarding ports and logic.
module store_queue_dfx #(
  parameter int DEPTH = 4,
  parameter int PLEN  = 56,
  parameter int XLEN  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 shutdown_req_i,
  output logic                 shutdown_ack_o,
  store_queue_dfx_if.slave     bus,
  input  logic                 commit_i,
  output logic                 commit_ready_o,
  output logic                 no_st_pending_o,
  output logic                 empty_o,
  input  logic [11:0]          page_offset_i,
  output logic                 page_offset_matches_o,
`ifdef STORE_FWD_EN
  input  logic [PLEN-1:0]      ld_paddr_i,
  input  logic [XLEN/8-1:0]    ld_be_i,
  output logic                 fwd_valid_o,
  output logic [XLEN-1:0]      fwd_data_o,
`endif
  output logic [1:0]           dbg_state_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_QUIESCED = 2'd2
  } state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, cm_ptr_q, cm_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   com_cnt_q, com_cnt_d, spec_cnt_q, spec_cnt_d;
  logic [CNT_W-1:0]   occ;

  logic [PLEN-1:0]    addr_q [DEPTH];
  logic [XLEN-1:0]    data_q [DEPTH];
  logic [XLEN/8-1:0]  be_q   [DEPTH];
  logic [1:0]         size_q [DEPTH];

  logic mem_req, pop, push_acc, commit_acc;

  assign occ        = com_cnt_q + spec_cnt_q;
  assign mem_req    = (com_cnt_q != '0) && (state_q != ST_QUIESCED);
  assign pop        = mem_req && bus.mem_gnt_i;
  assign commit_acc = commit_i && (spec_cnt_q != '0);
  // The slot freed by a same-cycle pop is reusable, so a full queue still accepts while draining.
  assign bus.ready_o = ((occ < DEPTH_C) || pop) && !shutdown_req_i;
  assign push_acc   = bus.valid_i && bus.ready_o && !flush_i;

  assign bus.mem_req_o  = mem_req;
  assign bus.mem_addr_o = addr_q[rd_ptr_q];
  assign bus.mem_data_o = data_q[rd_ptr_q];
  assign bus.mem_be_o   = be_q[rd_ptr_q];
  assign bus.mem_size_o = size_q[rd_ptr_q];

  assign commit_ready_o  = (spec_cnt_q != '0);
  assign no_st_pending_o = (com_cnt_q == '0);
  assign empty_o         = (occ == '0);
  assign shutdown_ack_o  = (state_q == ST_QUIESCED);
  assign dbg_state_o     = state_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (pop)        rd_ptr_d = rd_ptr_q + 1'b1;
    if (commit_acc) cm_ptr_d = cm_ptr_q + 1'b1;
    if (push_acc)   wr_ptr_d = wr_ptr_q + 1'b1;
    com_cnt_d  = com_cnt_q + CNT_W'(commit_acc) - CNT_W'(pop);
    spec_cnt_d = spec_cnt_q + CNT_W'(push_acc) - CNT_W'(commit_acc);
    // Flush rolls the write pointer back to the post-commit boundary.
    if (flush_i) begin
      wr_ptr_d   = cm_ptr_d;
      spec_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      com_cnt_q  <= '0;
      spec_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      com_cnt_q  <= com_cnt_d;
      spec_cnt_q <= spec_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      addr_q[wr_ptr_q] <= bus.paddr_i;
      data_q[wr_ptr_q] <= bus.data_i;
      be_q[wr_ptr_q]   <= bus.be_i;
      size_q[wr_ptr_q] <= bus.size_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:      if (shutdown_req_i) state_q <= ST_DRAIN;
        ST_DRAIN: begin
          if (!shutdown_req_i) state_q <= ST_RUN;
          else if ((com_cnt_q == '0) && (spec_cnt_q == '0) && !mem_req) state_q <= ST_QUIESCED;
        end
        ST_QUIESCED: if (!shutdown_req_i) state_q <= ST_RUN;
        default:     state_q <= ST_RUN;
      endcase
    end
  end

  // Entries are scanned by age from rd_ptr, so slot k is occupied when k < occupancy.
  logic [PTR_W-1:0] po_idx;
  logic             po_match;
  always_comb begin
    po_idx   = '0;
    po_match = bus.valid_i && bus.ready_o && (bus.paddr_i[11:3] == page_offset_i[11:3]);
    for (int k = 0; k < DEPTH; k++) begin
      po_idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < occ) && (addr_q[po_idx][11:3] == page_offset_i[11:3])) po_match = 1'b1;
    end
  end
  assign page_offset_matches_o = po_match;

  logic unused_po;
  assign unused_po = ^page_offset_i[2:0];

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0] fw_idx;
  logic             fw_valid;
  logic [XLEN-1:0]  fw_data;
  // Later (younger) matches overwrite earlier ones; a partially covering youngest match yields no forward.
  always_comb begin
    fw_idx   = '0;
    fw_valid = 1'b0;
    fw_data  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fw_idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < occ) && (addr_q[fw_idx][PLEN-1:3] == ld_paddr_i[PLEN-1:3])) begin
        fw_valid = ((be_q[fw_idx] & ld_be_i) == ld_be_i);
        fw_data  = fw_valid ? data_q[fw_idx] : '0;
      end
    end
  end
  assign fwd_valid_o = fw_valid;
  assign fwd_data_o  = fw_data;

  logic unused_ld;
  assign unused_ld = ^ld_paddr_i[2:0];
`endif

endmodule

// File: tb/tb_store_queue_dfx.sv
// Bench for store_queue_dfx: queue-level reference model, scoreboard of drained stores,
// directed scenarios followed by randomized traffic with shutdown phases.
module tb_store_queue_dfx;

  localparam int PLEN = 56;
  localparam int XLEN = 64;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [PLEN-1:0]   paddr;
    logic [XLEN-1:0]   data;
    logic [XLEN/8-1:0] be;
    logic [1:0]        size;
  } ent_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush, sd_req, sd_ack, commit, commit_ready, no_st_pending, empty, po_match;
  logic [11:0] page_offset;
  logic [1:0]  dbg_state;
  logic [PLEN-1:0]   ld_paddr;
  logic [XLEN/8-1:0] ld_be;
  logic              fwd_valid;
  logic [XLEN-1:0]   fwd_data;

  store_queue_dfx_if #(.PLEN(PLEN), .XLEN(XLEN)) sq_if ();

  store_queue_dfx #(.DEPTH(DEPTH), .PLEN(PLEN), .XLEN(XLEN)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .flush_i               (flush),
    .shutdown_req_i        (sd_req),
    .shutdown_ack_o        (sd_ack),
    .bus                   (sq_if),
    .commit_i              (commit),
    .commit_ready_o        (commit_ready),
    .no_st_pending_o       (no_st_pending),
    .empty_o               (empty),
    .page_offset_i         (page_offset),
    .page_offset_matches_o (po_match),
`ifdef STORE_FWD_EN
    .ld_paddr_i            (ld_paddr),
    .ld_be_i               (ld_be),
    .fwd_valid_o           (fwd_valid),
    .fwd_data_o            (fwd_data),
`endif
    .dbg_state_o           (dbg_state)
  );

`ifndef STORE_FWD_EN
  assign fwd_valid = 1'b0;
  assign fwd_data  = '0;
`endif

  // reference model and scoreboard
  ent_t spec_q[$];
  ent_t com_q[$];
  ent_t exp_q[$];
  bit   sd_d1, sd_d2, empty_d1;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // monitor: every granted request must match the oldest committed store
  always @(negedge clk) begin
    if (rst_n && sq_if.mem_req_o && sq_if.mem_gnt_i) begin
      if (exp_q.size() == 0) begin
        chk("drain_unexpected", 1'b1, 1'b0);
      end else begin
        chk("drain_addr", sq_if.mem_addr_o, exp_q[0].paddr);
        chk("drain_data", sq_if.mem_data_o, exp_q[0].data);
        chk("drain_be",   sq_if.mem_be_o,   exp_q[0].be);
        chk("drain_size", sq_if.mem_size_o, exp_q[0].size);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive_idle();
    sq_if.valid_i   = 1'b0;
    sq_if.paddr_i   = '0;
    sq_if.data_i    = '0;
    sq_if.be_i      = '0;
    sq_if.size_i    = '0;
    sq_if.mem_gnt_i = 1'b0;
    commit = 1'b0; flush = 1'b0; sd_req = 1'b0; page_offset = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    @(posedge clk); @(posedge clk); #1;
    spec_q.delete(); com_q.delete(); exp_q.delete();
    sd_d1 = 0; sd_d2 = 0; empty_d1 = 1;
    @(negedge clk);
    chk("rst_ready",        sq_if.ready_o,   1'b1);
    chk("rst_commit_ready", commit_ready,    1'b0);
    chk("rst_no_st_pend",   no_st_pending,   1'b1);
    chk("rst_empty",        empty,           1'b1);
    chk("rst_mem_req",      sq_if.mem_req_o, 1'b0);
    chk("rst_ack",          sd_ack,          1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // one clock cycle: drive, predict, check at negedge, advance the model
  task automatic cycle(input bit v, input logic [PLEN-1:0] pa, input logic [XLEN-1:0] d,
                       input logic [XLEN/8-1:0] be, input logic [1:0] sz, input bit cm,
                       input bit g, input bit fl, input bit sd, input logic [11:0] po);
    int   occ;
    bit   e_req, e_pop, e_ready, e_cr, e_nsp, e_empty, e_ack, e_po, e_fv;
    logic [XLEN-1:0] e_fd;
    ent_t head, nw, all_q[$];
    sq_if.valid_i = v; sq_if.paddr_i = pa; sq_if.data_i = d; sq_if.be_i = be; sq_if.size_i = sz;
    sq_if.mem_gnt_i = g; commit = cm; flush = fl; sd_req = sd; page_offset = po;
    nw = '{paddr: pa, data: d, be: be, size: sz};
    occ     = com_q.size() + spec_q.size();
    e_req   = com_q.size() != 0;
    e_pop   = e_req && g;
    e_ready = !sd && (occ < DEPTH || e_pop);
    e_cr    = spec_q.size() != 0;
    e_nsp   = com_q.size() == 0;
    e_empty = occ == 0;
    e_ack   = sd_d1 && sd_d2 && empty_d1;
    head    = e_req ? com_q[0] : '0;
    all_q   = {com_q, spec_q};
    e_po    = v && e_ready && (pa[11:3] == po[11:3]);
    e_fv    = 0;
    e_fd    = '0;
    foreach (all_q[i]) begin
      if (all_q[i].paddr[11:3] == po[11:3]) e_po = 1;
      if (all_q[i].paddr[PLEN-1:3] == ld_paddr[PLEN-1:3]) begin
        e_fv = ((all_q[i].be & ld_be) == ld_be);
        e_fd = e_fv ? all_q[i].data : '0;
      end
    end
    @(negedge clk);
    chk("ready",        sq_if.ready_o,   e_ready);
    chk("commit_ready", commit_ready,    e_cr);
    chk("no_st_pend",   no_st_pending,   e_nsp);
    chk("empty",        empty,           e_empty);
    chk("mem_req",      sq_if.mem_req_o, e_req);
    chk("shutdown_ack", sd_ack,          e_ack);
    chk("po_match",     po_match,        e_po);
    if (e_req) chk("head_addr", sq_if.mem_addr_o, head.paddr);
`ifdef STORE_FWD_EN
    chk("fwd_valid", fwd_valid, e_fv);
    chk("fwd_data",  fwd_data,  e_fd);
`endif
    if (e_pop) void'(com_q.pop_front());
    if (cm && spec_q.size() != 0) begin
      com_q.push_back(spec_q[0]);
      exp_q.push_back(spec_q[0]);
      void'(spec_q.pop_front());
    end
    if (fl) spec_q.delete();
    else if (v && e_ready) spec_q.push_back(nw);
    sd_d2 = sd_d1; sd_d1 = sd; empty_d1 = e_empty;
    @(posedge clk); #1;
  endtask

  task automatic cyc(input bit v, input logic [PLEN-1:0] pa, input bit cm, input bit g,
                     input bit fl, input bit sd);
    cycle(v, pa, {8'h00, pa}, 8'hFF, 2'd3, cm, g, fl, sd, 12'h000);
  endtask

  logic [PLEN-13:0] up_pool [2];

  initial begin
    logic [PLEN-1:0] pa;
    ld_paddr = '0; ld_be = '0;
    do_reset();

    // fill without commit; fifth push refused
    for (int i = 0; i < 4; i++) cyc(1, PLEN'(56'h1000 + i * 8), 0, 0, 0, 0);
    cyc(1, PLEN'(56'h2000), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0, 0, 0);
    // full and granting: push taken in the same cycle
    cyc(1, PLEN'(56'h3000), 0, 1, 0, 0);
    cyc(0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, '0, 1, 1, 0, 0);

    // held request stays stable without grant
    cyc(1, PLEN'(56'hA0), 0, 0, 0, 0);
    cyc(0, '0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, 0, 0, 0, 0);
    cyc(0, '0, 0, 1, 0, 0);
    cyc(0, '0, 0, 0, 0, 0);

    // flush with a same-cycle push
    cyc(1, PLEN'(56'hA8), 0, 0, 0, 0);
    cyc(1, PLEN'(56'hB0), 0, 0, 0, 0);
    cyc(1, PLEN'(56'hC8), 1, 0, 0, 0);
    cyc(1, PLEN'(56'hD0), 0, 0, 1, 0);
    cyc(0, '0, 0, 1, 0, 0);
    cyc(0, '0, 0, 0, 0, 0);

    // shutdown with two committed stores
    cyc(1, PLEN'(56'h100), 0, 0, 0, 0);
    cyc(1, PLEN'(56'h108), 1, 0, 0, 0);
    cyc(0, '0, 1, 0, 0, 0);
    cyc(1, PLEN'(56'h110), 0, 0, 0, 1);
    cyc(0, '0, 0, 1, 0, 1);
    cyc(0, '0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, PLEN'(56'h118), 0, 0, 0, 1);
    cyc(1, PLEN'(56'h120), 0, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 1, 0, 0);

    // reset with a pending ungranted request
    cyc(1, PLEN'(56'h200), 0, 0, 0, 0);
    cyc(0, '0, 1, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 0);
    do_reset();

`ifdef STORE_FWD_EN
    cycle(1, PLEN'(56'h1008), 64'hDEAD, 8'hFF, 2'd3, 0, 0, 0, 0, 12'h0);
    ld_paddr = PLEN'(56'h100C); ld_be = 8'hF0;
    cyc(0, '0, 0, 0, 0, 0);
    cycle(1, PLEN'(56'h2008), 64'hBEEF, 8'h0F, 2'd2, 0, 0, 0, 0, 12'h0);
    ld_paddr = PLEN'(56'h2008); ld_be = 8'hFF;
    cyc(0, '0, 0, 0, 0, 0);
    ld_paddr = '0; ld_be = '0;
    do_reset();
`endif

    // randomized traffic with periodic shutdown windows
    up_pool[0] = '0;
    up_pool[1] = PLEN'(44'h0000_0000_ABC) ;
    for (int t = 0; t < 800; t++) begin
      bit sdw;
      sdw = (t % 100) >= 70 && (t % 100) < 92;
      pa  = {up_pool[$urandom_range(0, 1)], 9'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
      ld_paddr = {up_pool[$urandom_range(0, 1)], 9'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
      ld_be    = 8'($urandom);
      cycle($urandom_range(0, 9) < 6, pa, {$urandom, $urandom}, 8'($urandom),
            2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            sdw ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1),
            $urandom_range(0, 15) == 0, sdw,
            {$urandom_range(0, 3) == 0 ? 9'h1FF : 9'($urandom_range(0, 3)), 3'($urandom_range(0, 7))});
    end
    for (int i = 0; i < 12; i++) cyc(0, '0, 1, 1, 0, 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
